// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared state encoding and slice width for the nibble-serial add sequencer.
package add_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int SLICE_W = 4;

endpackage

// File: rtl/add_seq_ctrl_if.sv
// add_seq_ctrl_if: operand and result valid/ready bundle for add_seq_ctrl.
// The op signal exists only when ADD_SEQ_SUB_EN is defined.
interface add_seq_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef ADD_SEQ_SUB_EN
  logic             op;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

`ifdef ADD_SEQ_SUB_EN
  modport master (output in_valid, a, b, cin, op, out_ready,
                  input  in_ready, out_valid, sum, cout, busy);
  modport slave  (input  in_valid, a, b, cin, op, out_ready,
                  output in_ready, out_valid, sum, cout, busy);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, busy);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, busy);
`endif

endinterface

// File: rtl/add4_slice.sv
// add4_slice: combinational 4-bit ripple-carry adder, the one arithmetic slice the sequencer reuses.
module add4_slice
  import add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[SLICE_W];
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: WIDTH-bit adder that reuses one 4-bit slice, one nibble per clock, LSB first.
// Defining ADD_SEQ_SUB_EN adds the op port and a subtract mode (a - b, cout = no borrow).
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  add_seq_ctrl_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  logic [1:0]         state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               cout_q;
  logic [IDX_W-1:0]   idx;
  logic [SLICE_W-1:0] a_nib;
  logic [SLICE_W-1:0] b_nib;
  logic [SLICE_W-1:0] s_nib;
  logic               co_nib;
  logic               accept;
  logic               carry_init;

  assign accept = bus.in_valid && (state_q == ST_IDLE);
  assign a_nib  = a_q[SLICE_W*idx +: SLICE_W];

`ifdef ADD_SEQ_SUB_EN
  logic op_q;

  // Subtract is a + ~b + 1: invert each b nibble and seed the carry chain with 1.
  assign b_nib      = op_q ? ~b_q[SLICE_W*idx +: SLICE_W] : b_q[SLICE_W*idx +: SLICE_W];
  assign carry_init = bus.op ? 1'b1 : bus.cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 1'b0;
    end else if (accept) begin
      op_q <= bus.op;
    end
  end
`else
  assign b_nib      = b_q[SLICE_W*idx +: SLICE_W];
  assign carry_init = bus.cin;
`endif

  add4_slice u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry_q),
    .s  (s_nib),
    .co (co_nib)
  );

  // Nibbles not yet reached keep their previous value; the result is only meaningful in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= carry_init;
            idx     <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[SLICE_W*idx +: SLICE_W] <= s_nib;
          carry_q <= co_nib;
          if (idx == IDX_LAST) begin
            cout_q  <= co_nib;
            state_q <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule
